// File: rtl/idli_pkg.sv
// Shared types for the idli UART receive FIFO.
// Slice/counter types, receiver states and the debug probe bundle.
package idli_pkg;

  localparam int URX_WORD_BITS = 16;

  typedef logic [1:0] ctr_t;
  typedef logic [3:0] slice_t;

  typedef enum logic [1:0] {
    URXF_IDLE = 2'd0,
    URXF_DATA = 2'd1,
    URXF_STOP = 2'd2
  } urxf_state_t;

  typedef struct packed {
    urxf_state_t state;
    logic [3:0]  bit_cnt;
    logic [1:0]  frame_idx;
    logic [7:0]  level;
  } urxf_debug_t;

endpackage

// File: rtl/idli_urx_fifo_m_if.sv
// EX-side slice handshake of the UART receive FIFO.
// EX drives the sync counter and accept; the receiver returns slice/valid.
interface idli_urx_fifo_m_if;
  import idli_pkg::*;

  ctr_t   urxf_ctr;
  logic   urxf_acp;
  slice_t urxf_data;
  logic   urxf_vld;

  modport master (
    output urxf_ctr,
    output urxf_acp,
    input  urxf_data,
    input  urxf_vld
  );

  modport slave (
    input  urxf_ctr,
    input  urxf_acp,
    output urxf_data,
    output urxf_vld
  );

endinterface

// File: rtl/idli_urxf_fifo_m.sv
// Generic DEPTH x W FIFO with wrap-bit pointers and combinational head.
// Callers only push when accepted and only pop when non-empty.
module idli_urxf_fifo_m #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned W     = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  level_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q;
  logic [AW:0]  rp_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + 1'b1;
      if (pop_i)  rp_q <= rp_q + 1'b1;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wp_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rp_q[AW-1:0]];
  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign level_o = wp_q - rp_q;

endmodule

// File: rtl/idli_urx_fifo_m.sv
// UART receiver: frames -> 16b words -> FIFO, head shown one slice per GCK.
// The line cannot be back-pressured, so a word arriving when full is dropped.
module idli_urx_fifo_m
  import idli_pkg::*;
#(
  parameter int unsigned FRAME_BITS = 8,
  parameter int unsigned DEPTH      = 2,
  parameter bit          STOP_EN    = 1'b1
) (
  input  logic               i_urxf_gck,
  input  logic               i_urxf_rst,
  idli_urx_fifo_m_if.slave   urxf_ex,
  input  logic               i_urxf_clr,
  input  logic               i_urxf_data,
  output logic               o_urxf_ovf,
  output logic               o_urxf_ferr,
  output urxf_debug_t        o_urxf_debug
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [1:0] FRM_LAST =
    2'(URX_WORD_BITS / FRAME_BITS - 1);
  localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

  urxf_state_t state_q, state_d;
  logic [3:0]  bit_q, bit_d;
  logic [1:0]  frm_q, frm_d;
  logic [15:0] asm_q, asm_d;
  logic        ovf_q, ferr_q;

  logic        push_req;
  logic        frame_done;
  logic        ferr_set;
  logic [3:0]  pos;

  logic        push_ok;
  logic        pop;
  logic        full;
  logic        empty;
  logic [15:0] head;
  logic [AW:0] lvl;

  assign pos = 4'(frm_q) * 4'(FRAME_BITS) + bit_q;

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    frm_d      = frm_q;
    asm_d      = asm_q;
    frame_done = 1'b0;
    ferr_set   = 1'b0;
    push_req   = 1'b0;
    unique case (state_q)
      URXF_IDLE: begin
        if (!i_urxf_data) begin
          state_d = URXF_DATA;
          bit_d   = '0;
        end
      end
      URXF_DATA: begin
        asm_d[pos] = i_urxf_data;
        bit_d      = bit_q + 1'b1;
        if (bit_q == BIT_LAST) begin
          bit_d = '0;
          if (STOP_EN) begin
            state_d = URXF_STOP;
          end else begin
            state_d    = URXF_IDLE;
            frame_done = 1'b1;
          end
        end
      end
      URXF_STOP: begin
        state_d = URXF_IDLE;
        if (i_urxf_data) begin
          frame_done = 1'b1;
        end else begin
          ferr_set = 1'b1;
          frm_d    = '0;
        end
      end
      default: state_d = URXF_IDLE;
    endcase
    if (frame_done) begin
      if (frm_q == FRM_LAST) begin
        frm_d    = '0;
        push_req = 1'b1;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
  end

  assign pop     = !empty && urxf_ex.urxf_acp &&
                   (urxf_ex.urxf_ctr == 2'd3);
  assign push_ok = push_req && (!full || pop);

  always_ff @(posedge i_urxf_gck or posedge i_urxf_rst) begin
    if (i_urxf_rst) begin
      state_q <= URXF_IDLE;
      bit_q   <= '0;
      frm_q   <= '0;
      asm_q   <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      frm_q   <= frm_d;
      asm_q   <= asm_d;
      // A set event in the clearing cycle still wins.
      ovf_q   <= (push_req && !push_ok) ||
                 (ovf_q && !i_urxf_clr);
      ferr_q  <= ferr_set || (ferr_q && !i_urxf_clr);
    end
  end

  idli_urxf_fifo_m #(
    .DEPTH (DEPTH),
    .W     (URX_WORD_BITS)
  ) u_fifo (
    .clk_i   (i_urxf_gck),
    .rst_i   (i_urxf_rst),
    .push_i  (push_ok),
    .pop_i   (pop),
    .wdata_i (asm_d),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (lvl)
  );

  assign urxf_ex.urxf_vld  = !empty;
  assign urxf_ex.urxf_data = empty ? '0 :
                             head[4*urxf_ex.urxf_ctr +: 4];

  assign o_urxf_ovf  = ovf_q;
  assign o_urxf_ferr = ferr_q;

  assign o_urxf_debug = '{
    state:     state_q,
    bit_cnt:   bit_q,
    frame_idx: frm_q,
    level:     8'(lvl)
  };

endmodule
